// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Stream handshake: a byte transfers on a rising clk edge where byte_valid_i
// and byte_ready_o are both 1. byte_i must be stable while byte_valid_i is 1.
// The write port is fire-and-forget: we_o is a one-cycle pulse with
// waddr_o/wdata_o valid in that same cycle; the memory cannot stall it.
interface imem_loader_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;

  // Loader side.
  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, we_o, waddr_o, wdata_o
  );

  // Stream source / memory side.
  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a framed byte stream (16-bit word count,
// little-endian payload words, XOR checksum byte), writes each assembled word
// into the instruction memory and keeps the core held in reset until a load
// finishes with a good checksum.
module imem_loader #(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  imem_loader_if.slave bus,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         cpu_hold_o,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [1:0]  lane_q;
  logic [7:0]  xor_q;
  logic [23:0] word_q;
  logic        we_q;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        err_q;
  logic        hold_q;

  logic        ready;
  logic        accept;
  logic [15:0] len_d;
  logic        len_ok;

  // Byte acceptance and length decode for the LEN_HI byte.
  always_comb begin
    ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
             (state_q == S_DATA)   || (state_q == S_CHK);
    accept = ready && bus.byte_valid_i;
    len_d  = {bus.byte_i, len_q[7:0]};
    len_ok = (len_d != 16'd0) && ({1'b0, len_d} <= DEPTH_L);
  end

  // Frame parser: state, word assembly, write pulse and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        // start_i is only honoured when no load is running.
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q <= S_LEN_LO;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
            xor_q   <= '0;
            hold_q  <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= bus.byte_i;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (len_ok) begin
              len_q[15:8] <= bus.byte_i;
              state_q     <= S_DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_q  <= xor_q ^ bus.byte_i;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: word_q[7:0]   <= bus.byte_i;
              2'd1: word_q[15:8]  <= bus.byte_i;
              2'd2: word_q[23:16] <= bus.byte_i;
              default: begin
                we_q    <= 1'b1;
                wdata_q <= {bus.byte_i, word_q};
                waddr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                idx_q   <= idx_q + 16'd1;
                if (idx_q == len_q - 16'd1) state_q <= S_CHK;
              end
            endcase
          end
        end
        S_CHK: begin
          if (accept) begin
            if (bus.byte_i == xor_q) begin
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.we_o         = we_q;
  assign bus.waddr_o      = waddr_q;
  assign bus.wdata_o      = wdata_q;
  assign busy_o           = ready;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign cpu_hold_o       = hold_q;
  assign dbg_state_o      = state_q;

endmodule
